uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Receive side of the board UART; counterpart of the 'g' transmitter.
//  - Samples PHYSICAL_UART_RX (8N1, LSB first) with the same bit-time count as the transmitter.
//  - Deserialises each frame into a byte and buffers it in a small FIFO.
//  - Presents bytes on a valid/ready interface to the CPU / LED stage.
//  - Flags framing errors and overruns.
// PARAMETERS
//  WTIME       32'h28B0  CLK cycles per bit (100 MHz / 9600 baud); must be >= 4
//  FIFO_DEPTH  4         byte entries in output FIFO; power of two, >= 2
// PORTS
//  CLK        in   1  system clock (PHYSICAL_CLOCK domain)
//  RESET_N    in   1  asynchronous, active-low reset
//  UART_RX    in   1  raw serial line, asynchronous to CLK, idle high
//  DATA       out  8  byte at FIFO head; valid only while VALID=1
//  VALID      out  1  FIFO non-empty
//  READY      in   1  consumer accepts DATA when VALID&&READY at posedge CLK
//  BUSY       out  1  frame in progress (state != IDLE)
//  FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low, byte discarded
//  OVERRUN    out  1  one-cycle pulse: good byte dropped, FIFO full with no pop
// BEHAVIOUR
//  Reset:
//  - RESET_N=0 asynchronously forces: state=IDLE, counters=0, FIFO empty, sync flops=1.
//  - All outputs read 0 during reset: DATA=8'h00, VALID, BUSY, FRAME_ERR, OVERRUN.
//  - Reset mid-frame aborts the frame; no partial byte is ever pushed.
//  Input and counters:
//  - UART_RX passes through a 2-flop synchroniser (reset value 1); rx_s = second flop.
//  - Bit counter ct is 32 bits; bit index idx is 3 bits.
//  FSM:
//  - IDLE: rx_s_prev=1 && rx_s=0 -> START, ct<=0.
//  - START: at ct==WTIME/2-1 (integer division), sample rx_s.
//    - rx_s=0 -> DATA, ct<=0, idx<=0.
//    - rx_s=1 -> IDLE (glitch rejected, nothing reported).
//  - DATA: at ct==WTIME-1, shift rx_s into shreg[idx] (LSB first), ct<=0.
//    - idx==7 -> STOP; otherwise idx<=idx+1.
//  - STOP: at ct==WTIME-1, sample rx_s, then -> IDLE.
//    - rx_s=1 -> push shreg.
//    - rx_s=0 -> FRAME_ERR=1 for one cycle, no push.
//    - A low line (break) cannot retrigger until rx_s is seen high again: IDLE needs a 1->0 edge.
//  - In all non-IDLE states, ct increments every cycle and is cleared at each sample point.
//  Sample timing and latency:
//  - Sample points sit at bit centres: start edge + 2 (sync) + WTIME/2 + k*WTIME.
//  - VALID rises the cycle after the stop-bit sample.
//  FIFO:
//  - Circular buffer with wr/rd pointers one bit wider than log2(FIFO_DEPTH); pointers wrap naturally.
//  - DATA/VALID are driven from the head entry; DATA is 0 when empty.
//  - Pop on VALID&&READY.
//  - Push while full with simultaneous pop: both occur, no overrun.
//  - Push while full without pop: byte dropped, OVERRUN=1 for one cycle, FIFO contents unchanged.
//  - READY while empty is ignored.
// STRUCTURE
//  - Package uart_pkg: typedef enum logic [1:0] {IDLE,START,DATA,STOP} uart_rx_state_t;
//    localparam UART_WTIME_9600 = 32'h28B0; shared with the transmitter.
//  - Sub-module byte_fifo #(DEPTH): CLK, RESET_N, push/wdata, pop, rdata, empty, full.
//    Reusable by a future buffered TX.
//  - Synchroniser, FSM and shift register stay in uart_rx.
// TESTING  (WTIME=16, FIFO_DEPTH=4 unless stated)
//  1. Drive frame 0x67 ('g') at 16 cycles/bit, READY=1.
//     -> VALID for exactly 1 cycle, DATA=8'h67, 1 cycle after the stop-bit sample; no error pulse.
//  2. Low pulse of 5 cycles on UART_RX from idle.
//     -> returns to IDLE after mid-start check; BUSY for <=8 cycles; VALID stays 0.
//  3. Frame 0xA5 with stop bit held 0.
//     -> FRAME_ERR one-cycle pulse, VALID stays 0.
//     -> after line goes high, next frame 0x3C received correctly.
//  4. READY=0; send 0x01..0x05.
//     -> after 4th byte VALID=1, DATA=0x01; 5th byte gives OVERRUN pulse.
//     -> then READY=1 pops 0x01,0x02,0x03,0x04 in order, VALID falls.
//  5. FIFO full; assert READY in exactly the stop-sample cycle of a 5th frame 0x55.
//     -> no OVERRUN; drain order 0x02,0x03,0x04,0x55.
//  6. Assert RESET_N=0 mid-DATA of frame 0xFF, release, then send 0x80.
//     -> outputs 0 during reset; only 0x80 delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the board UART (receiver and transmitter).
//   uart_rx_state_t : receiver frame state
//   UART_WTIME_9600 : clk cycles per bit at 100 MHz / 9600 baud
//   UART_DATA_BITS  : data bits per 8N1 frame
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam logic [31:0] UART_WTIME_9600 = 32'h28B0;
  localparam int          UART_DATA_BITS  = 8;

  // Sample offset of the start-bit check: the centre of the start bit.
  function automatic logic [31:0] half_bit_last(input logic [31:0] wtime);
    return (wtime / 32'd2) - 32'd1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Small circular byte FIFO. Pointers are one bit wider than the address so
// full and empty are told apart without a separate count.
//   CLK      in   clock
//   RESET_N  in   asynchronous active-low reset (FIFO empties)
//   push     in   write wdata this cycle (ignored if full and not popping)
//   wdata    in   8-bit write data
//   pop      in   drop the head entry (ignored if empty)
//   rdata    out  head entry, 8'h00 while empty
//   empty    out  no entries
//   full     out  DEPTH entries
// ---------------------------------------------------------------------------
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = pop && !w_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_do_push = push && (!w_full || w_do_pop);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign empty = w_empty;
  assign full  = w_full;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 LSB-first UART receiver with a byte FIFO on a valid/ready output.
//   CLK        in   system clock
//   RESET_N    in   asynchronous active-low reset
//   UART_RX    in   raw serial line, asynchronous, idle high
//   DATA       out  byte at FIFO head (8'h00 when empty)
//   VALID      out  FIFO non-empty
//   READY      in   consumer takes DATA on VALID && READY
//   BUSY       out  frame in progress
//   FRAME_ERR  out  one-cycle pulse: stop bit low, byte discarded
//   OVERRUN    out  one-cycle pulse: good byte dropped, FIFO full, no pop
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronised line
// START | counting to the start-bit centre to reject glitches
// DATA  | sampling 8 data bits at bit centres, LSB first
// STOP  | sampling the stop bit; push byte or flag framing error
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [31:0] WTIME      = UART_WTIME_9600,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       UART_RX,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       BUSY,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam logic [31:0] C_HALF_LAST = half_bit_last(WTIME);
  localparam logic [31:0] C_BIT_LAST  = WTIME - 32'd1;

  // Synchroniser and edge history, all reset to the idle (high) level so
  // release of reset never looks like a start edge.
  logic r_sync1;
  logic r_sync2;
  logic r_rx_prev;

  uart_rx_state_t r_state;
  uart_rx_state_t w_state_nxt;
  logic [31:0]    r_ct;
  logic [31:0]    w_ct_nxt;
  logic [2:0]     r_idx;
  logic [2:0]     w_idx_nxt;
  logic [7:0]     r_shreg;
  logic [7:0]     w_shreg_nxt;
  logic           w_push;
  logic           w_stop_bad;

  logic           r_frame_err;
  logic           r_overrun;

  logic [7:0]     w_fifo_rdata;
  logic           w_fifo_empty;
  logic           w_fifo_full;
  logic           w_pop;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= UART_RX;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_ct    <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ct    <= w_ct_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ct_nxt    = r_ct + 32'd1;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_push      = 1'b0;
    w_stop_bad  = 1'b0;

    case (r_state)
      IDLE: begin
        w_ct_nxt = '0;
        // Edge, not level: a held-low break line cannot retrigger.
        if (r_rx_prev && !r_sync2) w_state_nxt = START;
      end

      START: begin
        if (r_ct == C_HALF_LAST) begin
          w_ct_nxt = '0;
          if (!r_sync2) begin
            w_state_nxt = uart_pkg::DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      uart_pkg::DATA: begin
        if (r_ct == C_BIT_LAST) begin
          w_ct_nxt             = '0;
          w_shreg_nxt[r_idx]   = r_sync2;
          if (r_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end

      STOP: begin
        if (r_ct == C_BIT_LAST) begin
          w_ct_nxt    = '0;
          w_state_nxt = IDLE;
          if (r_sync2) w_push     = 1'b1;
          else         w_stop_bad = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_ct_nxt    = '0;
      end
    endcase
  end

  assign w_pop = !w_fifo_empty && READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= w_push && w_fifo_full && !w_pop;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (w_push),
    .wdata   (r_shreg_with_stop()),
    .pop     (w_pop),
    .rdata   (w_fifo_rdata),
    .empty   (w_fifo_empty),
    .full    (w_fifo_full)
  );

  // The push happens on the stop-sample edge, after the last data bit was
  // already shifted in, so the register holds the complete byte.
  function automatic logic [7:0] r_shreg_with_stop();
    return r_shreg;
  endfunction

  assign DATA      = w_fifo_rdata;
  assign VALID     = !w_fifo_empty;
  assign BUSY      = (r_state != IDLE);
  assign FRAME_ERR = r_frame_err;
  assign OVERRUN   = r_overrun;

endmodule
